// File: rtl/vga_fb_arbiter.sv
// Frame-buffer SRAM arbiter: display reads win every cycle, camera writes queue in a FIFO and drain into idle slots.
// Optional FB_ARB_OVF_CNT_EN adds a saturating dropped-write counter on oOvf_Cnt; otherwise oOvf_Cnt is tied to 0.
module vga_fb_arbiter #(
    parameter int ADDR_W   = 22,
    parameter int DATA_W   = 16,
    parameter int WF_DEPTH = 8
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic              iRd_Req,
    input  logic [ADDR_W-1:0] iRd_Addr,
    output logic [DATA_W-1:0] oRd_Data,
    output logic              oRd_Valid,
    input  logic              iWr_Valid,
    input  logic [ADDR_W-1:0] iWr_Addr,
    input  logic [DATA_W-1:0] iWr_Data,
    output logic              oWr_Ready,
    output logic [ADDR_W-1:0] oMem_Addr,
    output logic [DATA_W-1:0] oMem_WData,
    output logic              oMem_WE_N,
    output logic              oMem_OE_N,
    input  logic [DATA_W-1:0] iMem_RData,
    output logic [15:0]       oOvf_Cnt,
    output logic [1:0]        oGnt_State
);

    // Handshake: a camera word is transferred on a rising edge where iWr_Valid && oWr_Ready;
    // oWr_Ready depends only on registered FIFO pointers, never on iWr_Valid.

    localparam int PW = $clog2(WF_DEPTH);

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_RD   = 2'd1,
        GNT_WR   = 2'd2
    } gnt_t;

    gnt_t gnt_q, gnt_d;

    logic [PW:0]       wr_ptr, rd_ptr;
    logic [ADDR_W-1:0] fifo_addr [WF_DEPTH];
    logic [DATA_W-1:0] fifo_data [WF_DEPTH];
    logic              fifo_empty, fifo_full;
    logic              push, pop;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign oWr_Ready  = !fifo_full;
    assign push       = iWr_Valid && !fifo_full;
    assign pop        = (gnt_d == GNT_WR);
    assign head_addr  = fifo_addr[rd_ptr[PW-1:0]];
    assign head_data  = fifo_data[rd_ptr[PW-1:0]];
    assign oGnt_State = gnt_q;

    // Grant decision is purely combinational; it is registered together with the pins.
    always_comb begin
        gnt_d = GNT_NONE;
        if (iRd_Req) begin
            gnt_d = GNT_RD;
        end else if (!fifo_empty) begin
            gnt_d = GNT_WR;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            gnt_q <= GNT_NONE;
        end else begin
            gnt_q <= gnt_d;
        end
    end

    always_ff @(posedge iCLK) begin
        if (push) begin
            fifo_addr[wr_ptr[PW-1:0]] <= iWr_Addr;
            fifo_data[wr_ptr[PW-1:0]] <= iWr_Data;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Address and write data hold through idle cycles so the SRAM bus does not toggle needlessly.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            oMem_Addr  <= '0;
            oMem_WData <= '0;
            oMem_WE_N  <= 1'b1;
            oMem_OE_N  <= 1'b1;
        end else begin
            oMem_WE_N <= 1'b1;
            oMem_OE_N <= 1'b1;
            case (gnt_d)
                GNT_RD: begin
                    oMem_Addr <= iRd_Addr;
                    oMem_OE_N <= 1'b0;
                end
                GNT_WR: begin
                    oMem_Addr  <= head_addr;
                    oMem_WData <= head_data;
                    oMem_WE_N  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            oRd_Data  <= '0;
            oRd_Valid <= 1'b0;
        end else begin
            oRd_Valid <= (gnt_q == GNT_RD);
            if (gnt_q == GNT_RD) oRd_Data <= iMem_RData;
        end
    end

`ifdef FB_ARB_OVF_CNT_EN
    logic [15:0] ovf_q;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            ovf_q <= '0;
        end else if (iWr_Valid && fifo_full && (ovf_q != 16'hFFFF)) begin
            ovf_q <= ovf_q + 16'd1;
        end
    end

    assign oOvf_Cnt = ovf_q;
`else
    assign oOvf_Cnt = '0;
`endif

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter: reset, read pipeline, write starvation, full FIFO, push/pop at full, random mutex/order run.
module tb_vga_fb_arbiter;

    localparam int ADDR_W = 22;
    localparam int DATA_W = 16;
`ifdef FB_ARB_OVF_CNT_EN
    localparam int OVF_ON = 1;
`else
    localparam int OVF_ON = 0;
`endif

    logic              iCLK = 1'b0;
    logic              iRST_N;
    logic              iRd_Req;
    logic [ADDR_W-1:0] iRd_Addr;
    logic [DATA_W-1:0] oRd_Data;
    logic              oRd_Valid;
    logic              iWr_Valid;
    logic [ADDR_W-1:0] iWr_Addr;
    logic [DATA_W-1:0] iWr_Data;
    logic              oWr_Ready;
    logic [ADDR_W-1:0] oMem_Addr;
    logic [DATA_W-1:0] oMem_WData;
    logic              oMem_WE_N;
    logic              oMem_OE_N;
    logic [DATA_W-1:0] iMem_RData;
    logic [15:0]       oOvf_Cnt;
    logic [1:0]        oGnt_State;

    int n_checks = 0;
    int n_fail   = 0;

    logic [ADDR_W+DATA_W-1:0] exp_q[$];

    vga_fb_arbiter dut (
        .iCLK       (iCLK),
        .iRST_N     (iRST_N),
        .iRd_Req    (iRd_Req),
        .iRd_Addr   (iRd_Addr),
        .oRd_Data   (oRd_Data),
        .oRd_Valid  (oRd_Valid),
        .iWr_Valid  (iWr_Valid),
        .iWr_Addr   (iWr_Addr),
        .iWr_Data   (iWr_Data),
        .oWr_Ready  (oWr_Ready),
        .oMem_Addr  (oMem_Addr),
        .oMem_WData (oMem_WData),
        .oMem_WE_N  (oMem_WE_N),
        .oMem_OE_N  (oMem_OE_N),
        .iMem_RData (iMem_RData),
        .oOvf_Cnt   (oOvf_Cnt),
        .oGnt_State (oGnt_State)
    );

    // clock / reset
    always #5 iCLK = ~iCLK;

    // asynchronous SRAM model: read data is a fixed function of the address
    assign iMem_RData = oMem_Addr[15:0] ^ 16'hA5A5;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    // scoreboard: record accepted pushes, retire them against SRAM write strobes
    always @(posedge iCLK) begin
        if (iRST_N && iWr_Valid && oWr_Ready) exp_q.push_back({iWr_Addr, iWr_Data});
    end

    always @(negedge iCLK) begin
        if (iRST_N) begin
            check("mutex_oe_we", 32'(!oMem_OE_N && !oMem_WE_N), 32'd0);
            if (!oMem_WE_N) begin
                if (exp_q.size() == 0) begin
                    check("wr_expected", 32'(exp_q.size()), 32'd1);
                end else begin
                    logic [ADDR_W+DATA_W-1:0] e;
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(oMem_Addr), 32'(e[ADDR_W+DATA_W-1:DATA_W]));
                    check("wr_data", 32'(oMem_WData), 32'(e[DATA_W-1:0]));
                end
            end
        end
    end

    initial begin
        iRST_N = 1'b0; iRd_Req = 1'b0; iRd_Addr = '0;
        iWr_Valid = 1'b0; iWr_Addr = '0; iWr_Data = '0;
        #12;
        check("rst_we_n",   32'(oMem_WE_N), 32'd1);
        check("rst_oe_n",   32'(oMem_OE_N), 32'd1);
        check("rst_addr",   32'(oMem_Addr), 32'd0);
        check("rst_wdata",  32'(oMem_WData), 32'd0);
        check("rst_rvalid", 32'(oRd_Valid), 32'd0);
        check("rst_rdata",  32'(oRd_Data), 32'd0);
        check("rst_ready",  32'(oWr_Ready), 32'd1);
        check("rst_ovf",    32'(oOvf_Cnt), 32'd0);
        check("rst_gnt",    32'(oGnt_State), 32'd0);
        iRST_N = 1'b1;
        tick();

        // read pipeline: 0x100..0x102, data = addr ^ 0xA5A5
        iRd_Req = 1'b1; iRd_Addr = 22'h100;
        tick();
        check("rd_oe_n",   32'(oMem_OE_N), 32'd0);
        check("rd_addr0",  32'(oMem_Addr), 32'h100);
        check("rd_gnt",    32'(oGnt_State), 32'd1);
        check("rd_valid0", 32'(oRd_Valid), 32'd0);
        iRd_Addr = 22'h101;
        tick();
        check("rd_valid1", 32'(oRd_Valid), 32'd1);
        check("rd_data1",  32'(oRd_Data), 32'hA4A5);
        iRd_Addr = 22'h102;
        tick();
        check("rd_valid2", 32'(oRd_Valid), 32'd1);
        check("rd_data2",  32'(oRd_Data), 32'hA4A4);
        iRd_Req = 1'b0;
        tick();
        check("rd_valid3", 32'(oRd_Valid), 32'd1);
        check("rd_data3",  32'(oRd_Data), 32'hA4A7);
        tick();
        check("rd_valid4", 32'(oRd_Valid), 32'd0);
        check("rd_hold4",  32'(oRd_Data), 32'hA4A7);

        // write starvation under a held read request
        iRd_Req = 1'b1; iRd_Addr = 22'h0;
        for (int i = 0; i < 20; i++) begin
            iWr_Valid = (i < 3);
            iWr_Addr  = 22'h200 + 22'(i);
            iWr_Data  = 16'h1111 * 16'(i + 1);
            tick();
            check("starve_we_n", 32'(oMem_WE_N), 32'd1);
        end
        iWr_Valid = 1'b0; iRd_Req = 1'b0;
        tick();
        check("drain_we0", 32'(oMem_WE_N), 32'd0);
        check("drain_a0",  32'(oMem_Addr), 32'h200);
        check("drain_d0",  32'(oMem_WData), 32'h1111);
        tick();
        check("drain_we1", 32'(oMem_WE_N), 32'd0);
        check("drain_a1",  32'(oMem_Addr), 32'h201);
        check("drain_d1",  32'(oMem_WData), 32'h2222);
        tick();
        check("drain_we2", 32'(oMem_WE_N), 32'd0);
        check("drain_a2",  32'(oMem_Addr), 32'h202);
        check("drain_d2",  32'(oMem_WData), 32'h3333);
        tick();
        check("drain_we3", 32'(oMem_WE_N), 32'd1);

        // full FIFO: 10 offers while reads hold the port
        iRd_Req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            iWr_Valid = 1'b1;
            iWr_Addr  = 22'h400 + 22'(i);
            iWr_Data  = 16'(i);
            tick();
            check("full_ready", 32'(oWr_Ready), (i < 7) ? 32'd1 : 32'd0);
        end
        check("full_ovf", 32'(oOvf_Cnt), (OVF_ON != 0) ? 32'd2 : 32'd0);

        // push/pop while full: one-cycle read gap, offer held
        iRd_Req = 1'b0; iWr_Addr = 22'h300; iWr_Data = 16'hBEEF;
        tick();
        check("pp_we_n",  32'(oMem_WE_N), 32'd0);
        check("pp_ready", 32'(oWr_Ready), 32'd1);
        check("pp_ovf",   32'(oOvf_Cnt), (OVF_ON != 0) ? 32'd3 : 32'd0);
        iRd_Req = 1'b1;
        tick();
        check("pp_we_n2",  32'(oMem_WE_N), 32'd1);
        check("pp_ready2", 32'(oWr_Ready), 32'd0);
        iWr_Valid = 1'b0; iRd_Req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("full_drain_we", 32'(oMem_WE_N), 32'd0);
        end
        tick();
        check("full_drain_end", 32'(oMem_WE_N), 32'd1);
        check("full_drain_rdy", 32'(oWr_Ready), 32'd1);

        // random traffic: mutex and write order are checked by the scoreboard
        for (int i = 0; i < 10000; i++) begin
            iRd_Req   = 1'($urandom_range(0, 1));
            iRd_Addr  = 22'($urandom_range(0, 32'h3FFFFF));
            iWr_Valid = 1'($urandom_range(0, 1));
            iWr_Addr  = 22'($urandom_range(0, 32'h3FFFFF));
            iWr_Data  = 16'($urandom_range(0, 32'hFFFF));
            tick();
        end
        iRd_Req = 1'b0; iWr_Valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("rand_q_empty", 32'(exp_q.size()), 32'd0);

        // asynchronous reset while a write strobe is active
        iWr_Valid = 1'b1; iWr_Addr = 22'h55; iWr_Data = 16'h5555;
        tick();
        iWr_Valid = 1'b0;
        tick();
        check("mid_we_low", 32'(oMem_WE_N), 32'd0);
        #2 iRST_N = 1'b0;
        #1;
        check("mid_we_n",   32'(oMem_WE_N), 32'd1);
        check("mid_oe_n",   32'(oMem_OE_N), 32'd1);
        check("mid_rvalid", 32'(oRd_Valid), 32'd0);
        check("mid_ready",  32'(oWr_Ready), 32'd1);
        check("mid_addr",   32'(oMem_Addr), 32'd0);
        exp_q.delete();
        tick();
        iRST_N = 1'b1;
        tick();
        check("post_we_n", 32'(oMem_WE_N), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
